// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving datapath enables and mux selects.
// Define DM_HANDSHAKE_EN to stall in MEM until dm_ready; undefined, MEM is always one cycle.
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       dm_ready,
  output logic       PC_WE,
  output logic [1:0] NPC_SEL,
  output logic       IR_WE,
  output logic       GRF_WE,
  output logic [1:0] GRF_A3_MUX,
  output logic [1:0] GRF_WD_MUX,
  output logic       ALU_B_MUX,
  output logic [1:0] ALUOp,
  output logic       DM_WE,
  output logic [1:0] EXTOp,
  output logic [2:0] state,
  output logic       illegal
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  logic [2:0] state_q, state_d;
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal, legal;
  logic mem_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    is_r    = (opcode == 6'b000000);
    is_addu = is_r && (funct == 6'b100001);
    is_subu = is_r && (funct == 6'b100011);
    is_jr   = is_r && (funct == 6'b001000);
    is_ori  = (opcode == 6'b001101);
    is_lw   = (opcode == 6'b100011);
    is_sw   = (opcode == 6'b101011);
    is_beq  = (opcode == 6'b000100);
    is_lui  = (opcode == 6'b001111);
    is_jal  = (opcode == 6'b000011);
    legal   = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_jal;
  end

`ifdef DM_HANDSHAKE_EN
  assign mem_done = dm_ready;
`else
  logic unused_dm_ready;
  assign unused_dm_ready = dm_ready;
  assign mem_done = 1'b1;
`endif

  always_comb begin
    state_d    = FETCH;
    PC_WE      = 1'b0;
    NPC_SEL    = 2'd0;
    IR_WE      = 1'b0;
    GRF_WE     = 1'b0;
    GRF_A3_MUX = 2'd0;
    GRF_WD_MUX = 2'd0;
    ALU_B_MUX  = 1'b0;
    ALUOp      = 2'd0;
    DM_WE      = 1'b0;
    EXTOp      = 2'd0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        IR_WE   = 1'b1;
        PC_WE   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (is_jal) begin
          PC_WE   = 1'b1;
          NPC_SEL = 2'd2;
          state_d = WB;
        end else if (is_jr) begin
          PC_WE   = 1'b1;
          NPC_SEL = 2'd3;
        end else if (!legal) begin
          illegal = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_subu) begin
          ALUOp = 2'd1;
        end else if (is_ori) begin
          ALUOp     = 2'd2;
          ALU_B_MUX = 1'b1;
        end else if (is_lui) begin
          ALUOp     = 2'd3;
          ALU_B_MUX = 1'b1;
        end else if (is_lw || is_sw) begin
          ALU_B_MUX = 1'b1;
          EXTOp     = 2'd1;
        end else if (is_beq) begin
          ALUOp   = 2'd1;
          EXTOp   = 2'd1;
          NPC_SEL = 2'd1;
          PC_WE   = zero;
        end
        if (is_lw || is_sw)                          state_d = MEM;
        else if (is_addu || is_subu || is_ori || is_lui) state_d = WB;
      end
      MEM: begin
        if (is_sw) begin
          DM_WE   = 1'b1;
          state_d = mem_done ? FETCH : MEM;
        end else if (is_lw) begin
          state_d = mem_done ? WB : MEM;
        end
      end
      WB: begin
        GRF_WE = is_addu | is_subu | is_ori | is_lui | is_lw | is_jal;
        if (is_addu || is_subu) begin
          GRF_A3_MUX = 2'd1;
        end else if (is_lw) begin
          GRF_WD_MUX = 2'd1;
        end else if (is_jal) begin
          GRF_A3_MUX = 2'd2;
          GRF_WD_MUX = 2'd2;
        end
      end
      default: state_d = FETCH;
    endcase
    // Reset masks every output combinationally so an in-flight write is cut off the same cycle.
    if (reset) begin
      state_d    = FETCH;
      PC_WE      = 1'b0;
      NPC_SEL    = 2'd0;
      IR_WE      = 1'b0;
      GRF_WE     = 1'b0;
      GRF_A3_MUX = 2'd0;
      GRF_WD_MUX = 2'd0;
      ALU_B_MUX  = 1'b0;
      ALUOp      = 2'd0;
      DM_WE      = 1'b0;
      EXTOp      = 2'd0;
      illegal    = 1'b0;
    end
  end

  assign state = reset ? 3'd0 : state_q;

endmodule
